// File: rtl/parity_pkg.sv
// parity_pkg: shared definitions for the parity serializer and its
// neighbours (parity encoder bench, future receiver).
//   state_t      - serializer frame FSM states
//   START_BIT    - line level of the start bit
//   STOP_BIT     - line level of the stop bit and idle line
//   even_parity  - XOR reduction of a data word (zero-extend narrower words)
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Zero-extension does not change the XOR result, so callers with
    // words up to 32 bits can pass 32'(word).
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period timer for the parity serializer.
// Counts 0..BAUD_DIV-1 and pulses tick on the last cycle of each period.
// A clear restarts the period at count 0 on the next cycle.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   clr    - restart the bit period (asserted on FSM state changes)
//   tick   - high during the last cycle of a bit period
module baud_tick_gen #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_serializer.sv
// parity_serializer: shifts a data word plus its encoder parity bit out on
// a serial line as start | data MSB first | parity | stop, BAUD_DIV clock
// cycles per bit. Words are accepted over a valid/ready handshake in IDLE.
// Optional build macro PARITY_SERIALIZER_CHECK_EN: registers a parity
// mismatch flag at acceptance; without it par_err is tied low.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - upstream presents in_data/in_p
//   in_ready  - block accepts a word this cycle (registered, IDLE only)
//   in_data   - data word, MSB transmitted first
//   in_p      - even parity bit from the encoder, sent unmodified
//   tx        - serial line, idle high
//   busy      - frame in progress
//   par_err   - supplied parity mismatched the data of the current/last frame
//
// state  | meaning
// IDLE   | line high, waiting for a handshake
// START  | start bit on the line
// DATA   | data bits, MSB first, shifting every bit period
// PARITY | captured parity bit on the line
// STOP   | stop bit on the line, then back to IDLE
module parity_serializer
    import parity_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_p,
    output logic              tx,
    output logic              busy,
    output logic              par_err
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state, next_state;
    logic [DATA_W-1:0] shift_reg;
    logic              par_reg;
    logic [BW-1:0]     bit_cnt;
    logic              accept;
    logic              tick;
    logic              state_chg;

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_chg),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    next_state = START;
                    accept     = 1'b1;
                end
            end
            START:  if (tick) next_state = DATA;
            DATA:   if (tick && (bit_cnt == LAST_BIT)) next_state = PARITY;
            PARITY: if (tick) next_state = STOP;
            STOP:   if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Restarting the bit period on every transition aligns each bit with
    // the state that drives it.
    assign state_chg = (next_state != state);

    always_comb begin
        case (state)
            START:   tx = START_BIT;
            DATA:    tx = shift_reg[DATA_W-1];
            PARITY:  tx = par_reg;
            default: tx = STOP_BIT;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            par_reg   <= 1'b0;
            bit_cnt   <= '0;
            in_ready  <= 1'b0;
        end else begin
            in_ready <= (next_state == IDLE);
            if (accept) begin
                shift_reg <= in_data;
                par_reg   <= in_p;
            end else if ((state == DATA) && tick) begin
                shift_reg <= shift_reg << 1;
            end
            // Held at zero outside DATA so it always starts clean on entry.
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef PARITY_SERIALIZER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (accept) begin
            par_err <= even_parity(32'(in_data)) ^ in_p;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: doc/parity_serializer.md
# parity_serializer

Transmit-side stage directly downstream of the 4-input parity encoder. It accepts a data nibble together with its encoder-generated parity bit over a valid/ready handshake. It shifts the pair out on a single serial line as a framed word: start bit, data MSB first, parity, stop bit. Bit timing is a configurable number of clock cycles per bit.

## Interface
- DATA_W, 4, data bits per frame; must be ≥1
- BAUD_DIV, 4, clock cycles per serial bit; must be ≥1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents in_data/in_p
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  data word; bit DATA_W-1 = encoder input a
- in_p  input  1  parity bit from the encoder (even parity: ^in_data ^ in_p == 0)
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress
- par_err  output  1  supplied parity mismatched the data of the current/last frame

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, in_ready=1. When in_valid && in_ready:
  - capture in_data into the shift register and in_p into the parity register;
  - go to START.
- START: tx=0 for BAUD_DIV cycles, then go to DATA.
- DATA: tx = shift register MSB. The register shifts left every BAUD_DIV cycles. After DATA_W bits, go to PARITY.
- PARITY: tx = captured in_p for BAUD_DIV cycles, then go to STOP.
- STOP: tx=1 for BAUD_DIV cycles, then go to IDLE.
- in_ready = (state==IDLE), registered. busy = (state!=IDLE).
- Captured values are held for the whole frame. in_data/in_p changes after acceptance have no effect.
- in_valid outside IDLE is ignored. The word is not consumed; it is accepted on the next IDLE cycle if still presented.
- The parity bit is transmitted exactly as supplied and is never corrected.
- Baud counter width is $clog2(BAUD_DIV) bits, minimum 1. It counts 0..BAUD_DIV-1 and clears on every state change. With BAUD_DIV=1 each bit lasts one cycle.
- Bit counter width is $clog2(DATA_W+1) bits and clears on entry to DATA.

## Timing
- Reset (asynchronous, rst_n low) forces:
  - state=IDLE, tx=1, in_ready=0, busy=0, par_err=0;
  - shift, parity, baud and bit registers to 0.
- in_ready rises on the first clock edge after rst_n deasserts.
- Handshake at edge N drives tx=0, busy=1 and in_ready=0 from edge N+1 onward.
- Frame length is (DATA_W+3)*BAUD_DIV cycles. The last stop cycle is followed by one IDLE cycle (tx=1, in_ready=1).
- With in_valid held high, frames repeat with period (DATA_W+3)*BAUD_DIV+1.
- Reset asserted mid-frame aborts immediately: tx=1, the frame is lost, and no partial resume happens after release.

## Configuration
- PARITY_SERIALIZER_CHECK_EN defined:
  - at acceptance, par_err is registered as ^in_data ^ in_p;
  - it is valid from edge N+1 and held until the next acceptance.
- Undefined: par_err is constant 0 and no check logic is built. Serial output is identical in both builds.

## Structure
- Package parity_pkg holds:
  - the state enum;
  - START_BIT=1'b0 and STOP_BIT=1'b1;
  - function even_parity(data), shared with the encoder testbench and the future receiver.
- One natural sub-module: baud_tick_gen. It takes parameter BAUD_DIV, a clear input and a tick output, and pulses tick on the last cycle of each bit period.

## Test plan
- Reset check, DATA_W=4, BAUD_DIV=4: hold rst_n low, then release. Expect tx=1, busy=0, par_err=0, and in_ready=0 until the first edge after release.
- Basic frame: in_data=4'b1011, in_p=1, one handshake. tx must be 0,1,0,1,1,1,1, each value for exactly 4 cycles (28 cycles). in_ready returns to 1 on cycle 29; par_err=0.
- Back-to-back: in_valid held high with words 4'b0000/p=0, then 4'b1111/p=0. The second start bit begins exactly 29 cycles after the first.
- Parity error, macro defined: in_data=4'b0001, in_p=0. par_err=1 from edge N+1, and tx still sends parity 0. The next good word clears par_err. With the macro undefined, par_err stays 0.
- Ignored valid: pulse in_valid during the DATA state with different data. The frame in flight is unchanged and no extra frame is sent.
- Mid-frame reset: assert rst_n during PARITY. tx goes to 1 asynchronously; after release the line stays idle until a new handshake. Repeat the basic frame with BAUD_DIV=1: 7-cycle frame.
